// File: rtl/m_unit_seq_pkg.sv
// m_unit_seq_pkg
// Shared definitions for the sequential RISC-V M-extension unit:
//   - OP/M-extension opcode and func7 constants
//   - func3 operation enum (MUL..REMU)
//   - FSM state enum
//   - small decode helpers working on the raw instruction or on func3
package m_unit_seq_pkg;

  localparam logic [6:0] M_OPCODE = 7'b0110011;
  localparam logic [6:0] M_FUNC7  = 7'b0000001;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } m_func3_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_MUL    = 3'd2,
    ST_DIV    = 3'd3,
    ST_FIXUP  = 3'd4,
    ST_DONE   = 3'd5
  } m_state_e;

  // True when the instruction word belongs to the M extension.
  function automatic logic is_m_insn(input logic [31:0] insn);
    return (insn[6:0] == M_OPCODE) && (insn[31:25] == M_FUNC7);
  endfunction

  function automatic logic is_div_op(input m_func3_e f3);
    return f3 inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
  endfunction

  function automatic logic is_rem_op(input m_func3_e f3);
    return f3 inside {F3_REM, F3_REMU};
  endfunction

  // Signed divide/remainder: operands are made absolute and fixed up later.
  function automatic logic is_signed_div(input m_func3_e f3);
    return f3 inside {F3_DIV, F3_REM};
  endfunction

  // Multiplier operand signedness: MULH is s*s, MULHSU is s*u, the rest u*u.
  function automatic logic mul_rs1_signed(input m_func3_e f3);
    return f3 inside {F3_MULH, F3_MULHSU};
  endfunction

  function automatic logic mul_rs2_signed(input m_func3_e f3);
    return f3 == F3_MULH;
  endfunction

endpackage

// File: rtl/m_div_step.sv
// m_div_step
// Combinational restoring-division step retiring DIV_BITS quotient bits.
// The partial remainder is always smaller than the divisor on entry, so the
// shifted value fits in XLEN+1 bits and the top bit is zero after each
// conditional subtract.
// Ports:
//   rem_in   [XLEN-1:0]      partial remainder from the previous step
//   dvd_bits [DIV_BITS-1:0]  next dividend bits, MSB first
//   divisor  [XLEN-1:0]      divisor magnitude (never zero here)
//   rem_out  [XLEN-1:0]      partial remainder after DIV_BITS steps
//   q_bits   [DIV_BITS-1:0]  quotient bits produced, MSB first
module m_div_step #(
  parameter int XLEN     = 32,
  parameter int DIV_BITS = 1
) (
  input  logic [XLEN-1:0]     rem_in,
  input  logic [DIV_BITS-1:0] dvd_bits,
  input  logic [XLEN-1:0]     divisor,
  output logic [XLEN-1:0]     rem_out,
  output logic [DIV_BITS-1:0] q_bits
);

  logic [XLEN:0] r;

  always_comb begin
    q_bits = '0;
    r      = {1'b0, rem_in};
    for (int i = DIV_BITS - 1; i >= 0; i--) begin
      r = {r[XLEN-1:0], dvd_bits[i]};
      if (r >= {1'b0, divisor}) begin
        r         = r - {1'b0, divisor};
        q_bits[i] = 1'b1;
      end
    end
    rem_out = r[XLEN-1:0];
  end

endmodule

// File: rtl/m_unit_seq.sv
// m_unit_seq
// Sequential RISC-V M-extension unit on a PCPI-style coprocessor interface.
// FSM: IDLE -> DECODE -> (MUL | DIV | straight to FIXUP) -> FIXUP -> DONE -> IDLE.
// Handshake: an instruction is accepted only on an edge where the FSM is in
// IDLE, pcpi_valid is high and the word decodes as an M instruction; the
// operands are captured on that edge and later input changes are ignored.
// pcpi_busy is high in DECODE/MUL/DIV/FIXUP, and pcpi_ready/pcpi_wr pulse for
// exactly the DONE cycle with pcpi_rd holding the result (zero otherwise).
// Ports:
//   clk, resetn           clock; synchronous active-high reset
//   pcpi_valid/insn       instruction offer
//   pcpi_rs1/rs2 [XLEN]   operands
//   pcpi_ready/wr         one-cycle result pulse
//   pcpi_busy             operation in progress
//   pcpi_rd [XLEN]        result
//   dbg_state [2:0]       current FSM state (m_state_e encoding)
module m_unit_seq
  import m_unit_seq_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int DIV_BITS   = 1,
  parameter int MUL_STAGES = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            pcpi_valid,
  input  logic [31:0]     pcpi_insn,
  input  logic [XLEN-1:0] pcpi_rs1,
  input  logic [XLEN-1:0] pcpi_rs2,
  output logic            pcpi_ready,
  output logic            pcpi_wr,
  output logic            pcpi_busy,
  output logic [XLEN-1:0] pcpi_rd,
  output logic [2:0]      dbg_state
);

  localparam int DIV_ITERS = XLEN / DIV_BITS;
  localparam int CNT_W     = $clog2(DIV_ITERS) + 1;
  localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

  m_state_e        state_q, state_d;
  m_func3_e        f3_q;
  logic [XLEN-1:0] rs1_q, rs2_q;
  logic [XLEN-1:0] dvsr_q, quo_q, rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic            div0_q, ovf_q;
  logic            ready_q;
  logic [XLEN-1:0] rd_q;

  logic [2*XLEN-1:0] prod_pipe [0:MUL_STAGES];

  // Only opcode/func3/func7 matter; register fields are ignored.
  logic unused_insn_fields;
  assign unused_insn_fields = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  // ---------------------------------------------------------------- decode
  logic accept;
  logic dec_div0, dec_ovf;
  logic [XLEN-1:0] abs_rs1, abs_rs2;
  logic mul_last, div_last;

  assign accept   = (state_q == ST_IDLE) && pcpi_valid && is_m_insn(pcpi_insn);
  assign dec_div0 = (rs2_q == '0);
  assign dec_ovf  = is_signed_div(f3_q) && (rs1_q == XMIN) && (rs2_q == '1);
  assign abs_rs1  = (is_signed_div(f3_q) && rs1_q[XLEN-1]) ? -rs1_q : rs1_q;
  assign abs_rs2  = (is_signed_div(f3_q) && rs2_q[XLEN-1]) ? -rs2_q : rs2_q;
  assign mul_last = (cnt_q == CNT_W'(MUL_STAGES));
  assign div_last = (cnt_q == CNT_W'(DIV_ITERS - 1));

  // ---------------------------------------------------------------- FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!is_div_op(f3_q))         state_d = ST_MUL;
        else if (dec_div0 || dec_ovf) state_d = ST_FIXUP;
        else                          state_d = ST_DIV;
      end
      ST_MUL:    if (mul_last) state_d = ST_FIXUP;
      ST_DIV:    if (div_last) state_d = ST_FIXUP;
      ST_FIXUP:  state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // One counter serves both MUL (0..MUL_STAGES) and DIV (0..ITERS-1).
      if (state_q == ST_MUL || state_q == ST_DIV) cnt_q <= cnt_q + 1'b1;
      else                                        cnt_q <= '0;
    end
  end

  // ---------------------------------------------------------------- multiply
  logic [2*XLEN-1:0] mul_a, mul_b, prod_full;

  assign mul_a     = {{XLEN{mul_rs1_signed(f3_q) & rs1_q[XLEN-1]}}, rs1_q};
  assign mul_b     = {{XLEN{mul_rs2_signed(f3_q) & rs2_q[XLEN-1]}}, rs2_q};
  assign prod_full = mul_a * mul_b;

  // Operands are stable from DECODE on, so after MUL_STAGES+1 loads the
  // last pipe stage holds the product when FIXUP reads it.
  always_ff @(posedge clk) begin
    if (state_q == ST_DECODE || state_q == ST_MUL) begin
      prod_pipe[0] <= prod_full;
      for (int i = 1; i <= MUL_STAGES; i++) prod_pipe[i] <= prod_pipe[i-1];
    end
  end

  // ---------------------------------------------------------------- divide
  logic [XLEN-1:0]     step_rem;
  logic [DIV_BITS-1:0] step_q;

  m_div_step #(
    .XLEN     (XLEN),
    .DIV_BITS (DIV_BITS)
  ) u_div_step (
    .rem_in   (rem_q),
    .dvd_bits (quo_q[XLEN-1 -: DIV_BITS]),
    .divisor  (dvsr_q),
    .rem_out  (step_rem),
    .q_bits   (step_q)
  );

  // quo_q starts as the dividend magnitude; dividend bits shift out of the
  // top while quotient bits shift in at the bottom.
  always_ff @(posedge clk) begin
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          f3_q  <= m_func3_e'(pcpi_insn[14:12]);
          rs1_q <= pcpi_rs1;
          rs2_q <= pcpi_rs2;
        end
      end
      ST_DECODE: begin
        div0_q <= dec_div0;
        ovf_q  <= dec_ovf;
        rem_q  <= '0;
        quo_q  <= abs_rs1;
        dvsr_q <= abs_rs2;
      end
      ST_DIV: begin
        rem_q <= step_rem;
        quo_q <= {quo_q[XLEN-DIV_BITS-1:0], step_q};
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- fixup
  logic            neg_q, neg_r;
  logic [XLEN-1:0] q_fix, r_fix, result;

  assign neg_q = is_signed_div(f3_q) && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1]);
  assign neg_r = is_signed_div(f3_q) && rs1_q[XLEN-1];
  assign q_fix = neg_q ? -quo_q : quo_q;
  assign r_fix = neg_r ? -rem_q : rem_q;

  always_comb begin
    result = '0;
    if (!is_div_op(f3_q)) begin
      if (f3_q == F3_MUL) result = prod_pipe[MUL_STAGES][XLEN-1:0];
      else                result = prod_pipe[MUL_STAGES][2*XLEN-1:XLEN];
    end else if (div0_q) begin
      result = is_rem_op(f3_q) ? rs1_q : '1;
    end else if (ovf_q) begin
      result = is_rem_op(f3_q) ? '0 : XMIN;
    end else begin
      result = is_rem_op(f3_q) ? r_fix : q_fix;
    end
  end

  // ---------------------------------------------------------------- outputs
  always_ff @(posedge clk) begin
    if (resetn) begin
      ready_q <= 1'b0;
      rd_q    <= '0;
    end else begin
      ready_q <= (state_q == ST_FIXUP);
      rd_q    <= (state_q == ST_FIXUP) ? result : '0;
    end
  end

  assign pcpi_ready = ready_q;
  assign pcpi_wr    = ready_q;
  assign pcpi_rd    = rd_q;
  assign pcpi_busy  = state_q inside {ST_DECODE, ST_MUL, ST_DIV, ST_FIXUP};
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_m_unit_seq.sv
// tb_m_unit_seq
// Three instances share one stimulus stream: default parameters,
// DIV_BITS=2 and MUL_STAGES=3. A per-instance latency model predicts
// busy/ready/wr/rd for every cycle; results come from a directed table.
module tb_m_unit_seq;
  import m_unit_seq_pkg::*;

  localparam int NDUT = 3;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;

  logic        ready [NDUT];
  logic        wr    [NDUT];
  logic        busy  [NDUT];
  logic [31:0] rd    [NDUT];
  logic [2:0]  st    [NDUT];

  m_unit_seq #(.XLEN(32), .DIV_BITS(1), .MUL_STAGES(1)) u_dut0 (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_ready(ready[0]),
    .pcpi_wr(wr[0]), .pcpi_busy(busy[0]), .pcpi_rd(rd[0]), .dbg_state(st[0]));

  m_unit_seq #(.XLEN(32), .DIV_BITS(2), .MUL_STAGES(1)) u_dut1 (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_ready(ready[1]),
    .pcpi_wr(wr[1]), .pcpi_busy(busy[1]), .pcpi_rd(rd[1]), .dbg_state(st[1]));

  m_unit_seq #(.XLEN(32), .DIV_BITS(1), .MUL_STAGES(3)) u_dut2 (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_ready(ready[2]),
    .pcpi_wr(wr[2]), .pcpi_busy(busy[2]), .pcpi_rd(rd[2]), .dbg_state(st[2]));

  // ---------------------------------------------------------------- checking
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  function automatic int lat_of(input int d, input logic [31:0] insn,
                                input logic [31:0] a, input logic [31:0] b);
    int db, ms;
    logic [2:0] f3;
    db = (d == 1) ? 2 : 1;
    ms = (d == 2) ? 3 : 1;
    f3 = insn[14:12];
    if (f3 < 3'd4) return ms + 4;
    if (b == 32'h0) return 3;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 3;
    return 32 / db + 3;
  endfunction

  function automatic logic insn_match(input logic [31:0] insn);
    return (insn[6:0] == 7'b0110011) && (insn[31:25] == 7'b0000001);
  endfunction

  logic [31:0] cur_exp;
  logic [31:0] exp_q[$];
  logic        m_act [NDUT];
  int          m_cnt [NDUT];
  int          m_lat [NDUT];
  logic [31:0] m_exp [NDUT];
  logic        chk_en = 1'b0;

  // m_cnt is the cycle number since the accept edge; DONE is cycle m_lat.
  always @(posedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (resetn) begin
        m_act[d] <= 1'b0;
        m_cnt[d] <= 0;
        if (d == 0) exp_q.delete();
      end else if (!m_act[d]) begin
        if (pcpi_valid && insn_match(pcpi_insn)) begin
          m_act[d] <= 1'b1;
          m_cnt[d] <= 1;
          m_lat[d] <= lat_of(d, pcpi_insn, pcpi_rs1, pcpi_rs2);
          m_exp[d] <= cur_exp;
          if (d == 0) exp_q.push_back(cur_exp);
        end
      end else if (m_cnt[d] == m_lat[d]) begin
        m_act[d] <= 1'b0;
      end else begin
        m_cnt[d] <= m_cnt[d] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < NDUT; d++) begin
        logic e_ready, e_busy;
        logic [31:0] e_rd;
        e_ready = m_act[d] && (m_cnt[d] == m_lat[d]);
        e_busy  = m_act[d] && (m_cnt[d] < m_lat[d]);
        e_rd    = 32'h0;
        if (e_ready) begin
          if (d == 0) begin
            if (exp_q.size() == 0) check("sb_underflow", 64'd1, 64'd0);
            else e_rd = exp_q.pop_front();
          end else begin
            e_rd = m_exp[d];
          end
        end
        check($sformatf("ready[%0d]", d), 64'(ready[d]), 64'(e_ready));
        check($sformatf("wr[%0d]", d),    64'(wr[d]),    64'(e_ready));
        check($sformatf("busy[%0d]", d),  64'(busy[d]),  64'(e_busy));
        check($sformatf("rd[%0d]", d),    64'(rd[d]),    64'(e_rd));
      end
    end
  end

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_insn(input logic [2:0] f3);
    return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_act[0] || m_act[1] || m_act[2]) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("idle_timeout", 64'd1, 64'd0);
    tick();
  endtask

  // One-cycle offer; operands are scrambled afterwards so any late sampling
  // in the DUT shows up as a wrong result.
  task automatic issue(input logic [31:0] insn, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
    pcpi_insn  = insn;
    pcpi_rs1   = a;
    pcpi_rs2   = b;
    cur_exp    = exp;
    pcpi_valid = 1'b1;
    tick();
    pcpi_valid = 1'b0;
    pcpi_rs1   = $urandom;
    pcpi_rs2   = $urandom;
    wait_idle();
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct packed {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC] = '{
    '{F3_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
    '{F3_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
    '{F3_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{F3_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
    '{F3_MUL,    32'h1234_5678,  32'h10,        32'h2345_6780},
    '{F3_MULH,   32'hFFFF_FFFF,  32'd7,         32'hFFFF_FFFF},
    '{F3_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
    '{F3_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
    '{F3_DIVU,   32'd100,        32'd7,         32'd14},
    '{F3_REMU,   32'd100,        32'd7,         32'd2},
    '{F3_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF},
    '{F3_REM,    32'd5,          32'd0,         32'd5},
    '{F3_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
    '{F3_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
    '{F3_DIV,    32'd20,         32'hFFFF_FFFA, 32'hFFFF_FFFD},
    '{F3_REM,    32'd20,         32'hFFFF_FFFA, 32'd2},
    '{F3_REMU,   32'hFFFF_FFFF,  32'd16,        32'd15},
    '{F3_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF},
    '{F3_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0},
    '{F3_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000}
  };

  // ---------------------------------------------------------------- main
  initial begin
    resetn     = 1'b1;
    pcpi_valid = 1'b0;
    pcpi_insn  = 32'h0;
    pcpi_rs1   = 32'h0;
    pcpi_rs2   = 32'h0;
    cur_exp    = 32'h0;
    repeat (3) tick();
    chk_en = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("reset_state[%0d]", d), 64'(st[d]), 64'(ST_IDLE));
      check($sformatf("reset_busy[%0d]", d),  64'(busy[d]), 64'd0);
    end
    resetn = 1'b0;
    tick();

    // Directed result table, each op also checked cycle-by-cycle for timing.
    for (int i = 0; i < NVEC; i++)
      issue(mk_insn(vecs[i].f3), vecs[i].a, vecs[i].b, vecs[i].r);

    // Reset during DIV cycle 10: every instance is mid-division.
    pcpi_insn  = mk_insn(F3_DIVU);
    pcpi_rs1   = 32'd1000;
    pcpi_rs2   = 32'd3;
    cur_exp    = 32'd333;
    pcpi_valid = 1'b1;
    tick();
    pcpi_valid = 1'b0;
    repeat (10) tick();
    resetn = 1'b1;
    tick();
    resetn = 1'b0;
    for (int d = 0; d < NDUT; d++) begin
      check($sformatf("midrst_state[%0d]", d), 64'(st[d]),    64'(ST_IDLE));
      check($sformatf("midrst_busy[%0d]", d),  64'(busy[d]),  64'd0);
      check($sformatf("midrst_ready[%0d]", d), 64'(ready[d]), 64'd0);
    end
    repeat (40) tick();
    issue(mk_insn(F3_DIVU), 32'd9, 32'd3, 32'd3);

    // Back-to-back with pcpi_valid held: re-accept only from IDLE.
    pcpi_insn  = mk_insn(F3_MUL);
    pcpi_rs1   = 32'd3;
    pcpi_rs2   = 32'd5;
    cur_exp    = 32'd15;
    pcpi_valid = 1'b1;
    repeat (20) tick();
    pcpi_valid = 1'b0;
    wait_idle();

    // Non-M instructions: ADD (func7=0) and an OP-IMM word with func7=1.
    pcpi_insn  = {7'b0000000, 5'd2, 5'd1, 3'b000, 5'd3, 7'b0110011};
    pcpi_valid = 1'b1;
    repeat (8) tick();
    pcpi_insn  = {7'b0000001, 5'd2, 5'd1, 3'b100, 5'd3, 7'b0010011};
    repeat (8) tick();
    pcpi_valid = 1'b0;
    for (int d = 0; d < NDUT; d++)
      check($sformatf("nonm_state[%0d]", d), 64'(st[d]), 64'(ST_IDLE));
    tick();

    check("sb_leftover", 64'(exp_q.size()), 64'd0);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m_unit_seq.md
M_UNIT_SEQ -- requirements
Module: m_unit_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 32, 64.
REQ-002 SHALL have parameter DIV_BITS, default 1, quotient bits retired per DIV cycle; legal values 1, 2, 4.
REQ-003 SHALL have parameter MUL_STAGES, default 1, pipeline registers after the multiplier; legal values 0..3.
REQ-004 SHALL have one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 resetn  input  1  synchronous active-high reset (codebase port name).
REQ-007 pcpi_valid  input  1  instruction offered.
REQ-008 pcpi_insn  input  32  instruction word.
REQ-009 pcpi_rs1, pcpi_rs2  input  XLEN  operands.
REQ-010 pcpi_ready  output  1  result valid, one-cycle pulse.
REQ-011 pcpi_wr  output  1  register write request, equal to pcpi_ready.
REQ-012 pcpi_busy  output  1  operation in progress.
REQ-013 pcpi_rd  output  XLEN  result; zero when pcpi_ready is low.

Function
REQ-014 Accept edge: state IDLE, pcpi_valid=1, opcode=0110011, func7=0000001; func3, rs1 and rs2 SHALL be captured at this edge.
REQ-015 Non-matching instructions SHALL leave the FSM in IDLE with all outputs low.
REQ-016 FSM states: IDLE, DECODE, MUL, DIV, FIXUP, DONE; DONE SHALL always return to IDLE.
REQ-017 DECODE (1 cycle) SHALL compute absolute values for signed ops, detect divide-by-zero and signed overflow (MIN / -1), then go to MUL, DIV, or FIXUP (special case).
REQ-018 MUL SHALL last MUL_STAGES+1 cycles using a 2XLEN-bit product of sign-extended operands (MULH signed×signed, MULHSU signed×unsigned, MULHU/MUL unsigned).
REQ-019 DIV SHALL last XLEN/DIV_BITS cycles of restoring division, with an iteration counter of width clog2(XLEN/DIV_BITS)+1.
REQ-020 FIXUP (1 cycle) SHALL negate the quotient when operand signs differ (DIV) and negate the remainder when rs1<0 (REM).
REQ-021 Divide-by-zero: quotient all-ones, remainder rs1; signed overflow: quotient MIN, remainder 0; DIV state skipped.
REQ-022 Result: MUL takes low XLEN bits, other MUL variants high XLEN; DIV/DIVU take quotient, REM/REMU take remainder.
REQ-023 Latency, counted from the accept edge to the cycle with pcpi_ready high: MUL ops MUL_STAGES+4; DIV/REM XLEN/DIV_BITS+3; special cases 3.
REQ-024 pcpi_busy SHALL be high from the cycle after the accept edge through FIXUP and low in DONE and IDLE.
REQ-025 pcpi_ready, pcpi_wr and pcpi_rd SHALL be registered and valid only in DONE.
REQ-026 pcpi_valid deasserting or operands changing mid-operation SHALL NOT affect the result.
REQ-027 pcpi_valid high during DONE SHALL NOT be accepted; the earliest back-to-back accept is the edge at which the FSM is in IDLE.

Reset
REQ-028 resetn=1 at any edge, including mid-operation, SHALL force IDLE, counter 0, and pcpi_ready, pcpi_wr, pcpi_busy, pcpi_rd to 0 on that edge.
REQ-029 An operation aborted by reset SHALL produce no pcpi_ready pulse.

Structure
REQ-030 The shared package SHALL hold the OPCODE/FUNC7 constants, the func3 enum (MUL..REMU), the state enum, and decode helper functions.
REQ-031 One sub-module, m_div_step, SHALL implement a combinational DIV_BITS-bit restoring step (remainder, divisor → next remainder, quotient bits).
REQ-032 The design SHALL contain no latches; every combinational output SHALL be defaulted.

Verification
REQ-033 MUL 7 × 0xFFFFFFFD (XLEN=32) -> pcpi_rd=0xFFFFFFEB; MULH 0x80000000 × 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-034 DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-035 DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with pcpi_ready at cycle 3; DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0.
REQ-036 Latency sweep: DIV_BITS=2, XLEN=32 -> pcpi_ready at cycle 19; MUL_STAGES=3 -> cycle 7; busy/ready/wr timing checked every cycle.
REQ-037 resetn pulsed at DIV cycle 10 -> IDLE next cycle, no ready pulse; a following DIVU 9/3 -> 3 with correct latency.
REQ-038 Back-to-back ops with pcpi_valid held high -> second accepted only from IDLE; func7=0 instruction -> busy never asserts.
